// File: rtl/pjdl_axis_obi_port.sv
// pjdl_axis_obi_port: OBI subordinate that lets the CPU push single bytes onto
// the PJDL TX stream and pop bytes from the PJDL RX stream through small FIFOs.
// Register map (a[3:2]): 0 TX_DATA, 1 RX_DATA, 2 STATUS, 3 CTRL.
//
// Handshake semantics: on both AXI-Stream ports a byte moves in a cycle where
// tvalid and tready are both high at the rising edge; tvalid never depends on
// tready. On OBI, gnt mirrors req (no back-pressure) and rvalid follows every
// granted request exactly one cycle later, with registered rdata/rid.
module pjdl_axis_obi_port #(
  parameter int unsigned FifoDepth = 4,
  parameter int unsigned IdWidth   = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  // OBI request channel
  input  logic               obi_req_i,
  output logic               obi_gnt_o,
  input  logic [31:0]        obi_addr_i,
  input  logic               obi_we_i,
  input  logic [3:0]         obi_be_i,
  input  logic [31:0]        obi_wdata_i,
  input  logic [IdWidth-1:0] obi_aid_i,
  // OBI response channel
  output logic               obi_rvalid_o,
  output logic [31:0]        obi_rdata_o,
  output logic [IdWidth-1:0] obi_rid_o,
  output logic               obi_err_o,
  // byte stream toward PJDL
  output logic               axis_tx_tvalid_o,
  output logic [7:0]         axis_tx_tdata_o,
  output logic               axis_tx_tlast_o,
  output logic               axis_tx_tkeep_o,
  output logic               axis_tx_tstrb_o,
  output logic               axis_tx_tuser_o,
  input  logic               axis_tx_tready_i,
  // byte stream from PJDL
  input  logic               axis_rx_tvalid_i,
  input  logic [7:0]         axis_rx_tdata_i,
  input  logic               axis_rx_tlast_i,
  input  logic               axis_rx_tkeep_i,
  input  logic               axis_rx_tstrb_i,
  input  logic               axis_rx_tuser_i,
  output logic               axis_rx_tready_o,
  output logic               irq_o
);

  localparam int unsigned CntW = $clog2(FifoDepth + 1);
  localparam int unsigned PtrW = $clog2(FifoDepth);

  // FIFO storage: each entry is {last, data}
  logic [8:0]      tx_mem [FifoDepth];
  logic [8:0]      rx_mem [FifoDepth];
  logic [PtrW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [CntW-1:0] tx_count, rx_count;

  logic tx_ovf, rx_irq_en, tx_irq_en;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic [1:0] sel;
  logic tx_wr_try, tx_push, tx_pop, tx_ovf_set, ovf_clr, ctrl_wr;
  logic rx_push, rx_pop;
  logic [31:0] rd_data, status;

  // Address, status flags and all FIFO/register strobes for this cycle
  always_comb begin
    sel        = obi_addr_i[3:2];
    tx_full    = (tx_count == CntW'(FifoDepth));
    tx_empty   = (tx_count == '0);
    rx_full    = (rx_count == CntW'(FifoDepth));
    rx_empty   = (rx_count == '0);
    tx_wr_try  = obi_req_i & obi_we_i & (sel == 2'd0) & obi_be_i[0];
    tx_push    = tx_wr_try & ~tx_full;
    tx_ovf_set = tx_wr_try & tx_full;
    tx_pop     = ~tx_empty & axis_tx_tready_i;
    rx_push    = axis_rx_tvalid_i & ~rx_full;
    rx_pop     = obi_req_i & ~obi_we_i & (sel == 2'd1) & ~rx_empty;
    ovf_clr    = obi_req_i & obi_we_i & (sel == 2'd2) & obi_be_i[0] & obi_wdata_i[4];
    ctrl_wr    = obi_req_i & obi_we_i & (sel == 2'd3) & obi_be_i[0];
  end

  // Read data mux, built from the state at the start of the request cycle
  always_comb begin
    status = {8'h00, {(8-CntW){1'b0}}, rx_count, {(8-CntW){1'b0}}, tx_count,
              3'b000, tx_ovf, rx_full, rx_empty, tx_empty, tx_full};
    rd_data = '0;
    case (sel)
      2'd1:    rd_data = rx_empty ? 32'h0 : {1'b1, 22'h0, rx_mem[rx_rd_ptr]};
      2'd2:    rd_data = status;
      2'd3:    rd_data = {30'h0, tx_irq_en, rx_irq_en};
      default: rd_data = '0;
    endcase
  end

  // FIFO payload writes; storage needs no reset since counts gate visibility
  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= obi_wdata_i[8:0];
    if (rx_push) rx_mem[rx_wr_ptr] <= {axis_rx_tlast_i, axis_rx_tdata_i};
  end

  // TX FIFO pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PtrW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PtrW'(1);
      if (tx_push && !tx_pop)      tx_count <= tx_count + CntW'(1);
      else if (!tx_push && tx_pop) tx_count <= tx_count - CntW'(1);
    end
  end

  // RX FIFO pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PtrW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PtrW'(1);
      if (rx_push && !rx_pop)      rx_count <= rx_count + CntW'(1);
      else if (!rx_push && rx_pop) rx_count <= rx_count - CntW'(1);
    end
  end

  // Control bits, sticky overflow flag and the registered interrupt
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_irq_en <= 1'b0;
      tx_irq_en <= 1'b0;
      tx_ovf    <= 1'b0;
      irq_o     <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        rx_irq_en <= obi_wdata_i[0];
        tx_irq_en <= obi_wdata_i[1];
      end
      if (tx_ovf_set)   tx_ovf <= 1'b1;
      else if (ovf_clr) tx_ovf <= 1'b0;
      irq_o <= (rx_irq_en & ~rx_empty) | (tx_irq_en & tx_empty);
    end
  end

  // OBI response: one cycle after every granted request; writes return 0
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      obi_rvalid_o <= 1'b0;
      obi_rdata_o  <= '0;
      obi_rid_o    <= '0;
    end else begin
      obi_rvalid_o <= obi_req_i;
      if (obi_req_i) begin
        obi_rdata_o <= obi_we_i ? 32'h0 : rd_data;
        obi_rid_o   <= obi_aid_i;
      end
    end
  end

  assign obi_gnt_o        = obi_req_i;
  assign obi_err_o        = 1'b0;
  assign axis_tx_tvalid_o = ~tx_empty;
  assign axis_tx_tdata_o  = tx_empty ? 8'h00 : tx_mem[tx_rd_ptr][7:0];
  assign axis_tx_tlast_o  = ~tx_empty & tx_mem[tx_rd_ptr][8];
  assign axis_tx_tkeep_o  = 1'b1;
  assign axis_tx_tstrb_o  = 1'b1;
  assign axis_tx_tuser_o  = 1'b0;
  assign axis_rx_tready_o = ~rx_full;

  // Inputs that carry no meaning for this block
  logic unused_inputs;
  assign unused_inputs = ^{obi_addr_i[31:4], obi_addr_i[1:0], obi_be_i[3:1],
                           obi_wdata_i[31:9], axis_rx_tkeep_i, axis_rx_tstrb_i,
                           axis_rx_tuser_i};

endmodule

// File: tb/tb_pjdl_axis_obi_port.sv
// Directed testbench for pjdl_axis_obi_port: register map, TX/RX streams,
// overflow, full/empty boundaries, interrupt timing and asynchronous reset.
module tb_pjdl_axis_obi_port;

  localparam int unsigned IdWidth = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               obi_req = 1'b0, obi_we = 1'b0, obi_gnt;
  logic [31:0]        obi_addr = '0, obi_wdata = '0;
  logic [3:0]         obi_be = '0;
  logic [IdWidth-1:0] obi_aid = '0, obi_rid;
  logic               obi_rvalid, obi_err;
  logic [31:0]        obi_rdata;
  logic               tx_tvalid, tx_tlast, tx_tkeep, tx_tstrb, tx_tuser;
  logic [7:0]         tx_tdata;
  logic               tx_tready = 1'b0;
  logic               rx_tvalid = 1'b0, rx_tlast = 1'b0;
  logic [7:0]         rx_tdata = '0;
  logic               rx_tready, irq;

  pjdl_axis_obi_port #(.FifoDepth(4), .IdWidth(IdWidth)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .obi_req_i(obi_req), .obi_gnt_o(obi_gnt), .obi_addr_i(obi_addr),
    .obi_we_i(obi_we), .obi_be_i(obi_be), .obi_wdata_i(obi_wdata),
    .obi_aid_i(obi_aid), .obi_rvalid_o(obi_rvalid), .obi_rdata_o(obi_rdata),
    .obi_rid_o(obi_rid), .obi_err_o(obi_err),
    .axis_tx_tvalid_o(tx_tvalid), .axis_tx_tdata_o(tx_tdata),
    .axis_tx_tlast_o(tx_tlast), .axis_tx_tkeep_o(tx_tkeep),
    .axis_tx_tstrb_o(tx_tstrb), .axis_tx_tuser_o(tx_tuser),
    .axis_tx_tready_i(tx_tready),
    .axis_rx_tvalid_i(rx_tvalid), .axis_rx_tdata_i(rx_tdata),
    .axis_rx_tlast_i(rx_tlast), .axis_rx_tkeep_i(1'b1),
    .axis_rx_tstrb_i(1'b1), .axis_rx_tuser_i(1'b0),
    .axis_rx_tready_o(rx_tready), .irq_o(irq)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks (called at a negedge, return at a negedge) ----
  task automatic obi_access(input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be,
                            output logic [31:0] rdata);
    logic [IdWidth-1:0] id;
    id        = IdWidth'($urandom_range(0, (1 << IdWidth) - 1));
    obi_req   = 1'b1;
    obi_we    = we;
    obi_addr  = addr;
    obi_wdata = wdata;
    obi_be    = be;
    obi_aid   = id;
    #1;
    check("gnt", 32'(obi_gnt), 32'h1);
    @(posedge clk);
    @(negedge clk);
    obi_req = 1'b0;
    obi_we  = 1'b0;
    check("rvalid", 32'(obi_rvalid), 32'h1);
    check("rid", 32'(obi_rid), 32'(id));
    rdata = obi_rdata;
  endtask

  task automatic obi_write(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    logic [31:0] d;
    obi_access(1'b1, addr, wdata, be, d);
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    obi_access(1'b0, addr, 32'h0, 4'hF, d);
    check(tag, d, exp);
  endtask

  task automatic rx_send(input logic [7:0] data, input logic last);
    rx_tvalid = 1'b1;
    rx_tdata  = data;
    rx_tlast  = last;
    @(negedge clk);
    rx_tvalid = 1'b0;
  endtask

  // Raise tready and compare every byte against exp_q, then expect idle
  task automatic drain_tx(input string tag);
    tx_tready = 1'b1;
    while (exp_q.size() > 0) begin
      #1;
      check({tag, "_tvalid"}, 32'(tx_tvalid), 32'h1);
      check({tag, "_byte"}, {23'h0, tx_tlast, tx_tdata}, 32'(exp_q.pop_front()));
      @(negedge clk);
    end
    #1;
    check({tag, "_idle"}, 32'(tx_tvalid), 32'h0);
    tx_tready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("rst_rvalid", 32'(obi_rvalid), 32'h0);
    check("rst_rdata", obi_rdata, 32'h0);
    check("rst_tvalid", 32'(tx_tvalid), 32'h0);
    check("rst_tdata", 32'(tx_tdata), 32'h0);
    check("rst_rx_tready", 32'(rx_tready), 32'h1);
    check("rst_irq", 32'(irq), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    read_check("status_rst", 32'h8, 32'h0000_0006);
    check("err", 32'(obi_err), 32'h0);

    // TX: two bytes queued while tready is low, then drained in order
    obi_write(32'h0, 32'h1A5, 4'h1);
    #1;
    check("tx_tvalid_after_wr", 32'(tx_tvalid), 32'h1);
    check("tx_keep_strb_user", {29'h0, tx_tkeep, tx_tstrb, tx_tuser}, 32'h6);
    obi_write(32'h0, 32'h03C, 4'hF);
    exp_q.push_back(9'h1A5);
    exp_q.push_back(9'h03C);
    read_check("tx_data_reads_0", 32'h0, 32'h0);
    drain_tx("tx2");

    // TX overflow: five writes into a depth-4 FIFO
    for (int i = 0; i < 5; i++) begin
      obi_write(32'h0, 32'h50 + 32'(i), 4'hF);
      if (i < 4) exp_q.push_back(9'h50 + 9'(i));
    end
    read_check("status_ovf", 32'h1000_0008, 32'h0000_0415);
    obi_write(32'h8, 32'h10, 4'h1);
    read_check("status_ovf_clr", 32'h8, 32'h0000_0405);
    drain_tx("tx_ovf");

    // RX: two bytes buffered, then read out
    rx_send(8'h11, 1'b0);
    rx_send(8'h22, 1'b1);
    read_check("status_rx2", 32'h8, 32'h0002_0002);
    read_check("rx_rd0", 32'h4, 32'h8000_0011);
    read_check("rx_rd1", 32'h4, 32'h8000_0122);
    read_check("rx_rd_empty", 32'h4, 32'h0000_0000);

    // RX read while empty, same cycle as a stream push: byte stays queued
    rx_tvalid = 1'b1;
    rx_tdata  = 8'h77;
    rx_tlast  = 1'b0;
    read_check("rx_rd_race", 32'h4, 32'h0000_0000);
    rx_tvalid = 1'b0;
    read_check("status_race", 32'h8, 32'h0001_0002);
    read_check("rx_rd_race_byte", 32'h4, 32'h8000_0077);

    // RX full: tready drops, one read reopens it on the following cycle
    for (int i = 1; i <= 4; i++) rx_send(8'(i), 1'b0);
    #1;
    check("rx_tready_full", 32'(rx_tready), 32'h0);
    rx_tvalid = 1'b1;
    rx_tdata  = 8'hEE;
    @(negedge clk);
    rx_tvalid = 1'b0;
    read_check("status_rx_full", 32'h8, 32'h0004_000A);
    read_check("rx_full_rd", 32'h4, 32'h8000_0001);
    #1;
    check("rx_tready_reopen", 32'(rx_tready), 32'h1);
    read_check("rx_full_rd2", 32'h4, 32'h8000_0002);
    read_check("rx_full_rd3", 32'h4, 32'h8000_0003);
    read_check("rx_full_rd4", 32'h4, 32'h8000_0004);
    read_check("rx_drained", 32'h4, 32'h0);

    // Interrupts
    obi_write(32'hC, 32'hFFFF_FFFD, 4'hF);
    read_check("ctrl_rx_en", 32'hC, 32'h1);
    check("irq_idle", 32'(irq), 32'h0);
    rx_send(8'h5A, 1'b0);
    @(negedge clk);
    check("irq_rx_set", 32'(irq), 32'h1);
    read_check("irq_rx_byte", 32'h4, 32'h8000_005A);
    @(negedge clk);
    check("irq_rx_clr", 32'(irq), 32'h0);
    obi_write(32'hC, 32'h2, 4'h1);
    @(negedge clk);
    check("irq_tx_empty", 32'(irq), 32'h1);
    read_check("ctrl_tx_en", 32'hC, 32'h2);

    // Asynchronous reset in the middle of activity
    obi_write(32'hC, 32'h1, 4'h1);
    obi_write(32'h0, 32'h099, 4'h1);
    rx_send(8'h33, 1'b1);
    @(negedge clk);
    check("irq_pre_rst", 32'(irq), 32'h1);
    obi_req  = 1'b1;
    obi_we   = 1'b0;
    obi_addr = 32'h8;
    @(posedge clk);
    #2;
    check("rvalid_pre_rst", 32'(obi_rvalid), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_async_rvalid", 32'(obi_rvalid), 32'h0);
    check("rst_async_tvalid", 32'(tx_tvalid), 32'h0);
    check("rst_async_irq", 32'(irq), 32'h0);
    obi_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    read_check("status_post_rst", 32'h8, 32'h0000_0006);
    read_check("ctrl_post_rst", 32'hC, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
